// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, a..g on bits 0..6.
package sseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the pattern for hex digit n (index 15 first).
  localparam logic [15:0][6:0] HEX_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display-side bundle: packed digit data and controls in,
// digit enables and segment drives out.
interface sseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 6
);

  logic [4*NUM_DIGITS-1:0] DATA_IN;
  logic [NUM_DIGITS-1:0]   DP_IN;
  logic                    BLANK_LZ;
  logic [3:0]              BRIGHT;
  logic [NUM_DIGITS-1:0]   SEL;
  logic [6:0]              HEX;
  logic                    DP;
  logic                    FRAME_START;

  modport master (
    output DATA_IN,
    output DP_IN,
    output BLANK_LZ,
    output BRIGHT,
    input  SEL,
    input  HEX,
    input  DP,
    input  FRAME_START
  );

  modport slave (
    input  DATA_IN,
    input  DP_IN,
    input  BLANK_LZ,
    input  BRIGHT,
    output SEL,
    output HEX,
    output DP,
    output FRAME_START
  );

endinterface

// File: rtl/sseg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational lookup into the shared table.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_TAB[i_nib];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode scan controller with blanking,
// leading-zero suppression, PWM dimming and frame snapshots.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic CLOCK,
  input  logic RESET,
  sseg_scan_ctrl_if.slave bus
);

  localparam int MAX_C =
    (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam state_t ST_FIRST =
    (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DWELL_LAST =
    CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] D_LAST =
    IDX_W'(NUM_DIGITS - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_d;
  logic [3:0]            r_p;
  logic                  r_run;

  logic [DW-1:0]         r_data;
  logic [NUM_DIGITS-1:0] r_dp;
  logic                  r_lz;
  logic [3:0]            r_bright;

  logic [NUM_DIGITS-1:0] r_sel;
  logic [6:0]            r_hex;
  logic                  r_dpo;
  logic                  r_fs;

  state_t                w_state_n;
  logic [CNT_W-1:0]      w_cnt_n;
  logic [IDX_W-1:0]      w_d_n;
  logic [3:0]            w_p_n;
  logic                  w_snap;

  logic [DW-1:0]         w_data_n;
  logic [NUM_DIGITS-1:0] w_dp_n;
  logic                  w_lz_n;
  logic [3:0]            w_bright_n;

  logic [NUM_DIGITS-1:0] w_sup;
  logic                  w_zero;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic                  w_on;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_sel_n;
  logic [6:0]            w_hex_n;
  logic                  w_dpo_n;

  // r_run low means the next cycle opens digit 0 of a fresh frame.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_d_n     = r_d;
    w_p_n     = r_p;
    w_snap    = 1'b0;
    if (!r_run) begin
      w_state_n = ST_FIRST;
      w_cnt_n   = '0;
      w_d_n     = '0;
      w_p_n     = '0;
      w_snap    = 1'b1;
    end else begin
      unique case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_n = ST_ON;
            w_cnt_n   = '0;
            w_p_n     = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_n = ST_FIRST;
            w_cnt_n   = '0;
            w_p_n     = '0;
            w_d_n     = (r_d == D_LAST) ? '0 : r_d + 1'b1;
            w_snap    = (r_d == D_LAST);
          end else begin
            w_cnt_n = r_cnt + 1'b1;
            w_p_n   = r_p + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_data_n   = w_snap ? bus.DATA_IN  : r_data;
  assign w_dp_n     = w_snap ? bus.DP_IN    : r_dp;
  assign w_lz_n     = w_snap ? bus.BLANK_LZ : r_lz;
  assign w_bright_n = w_snap ? bus.BRIGHT   : r_bright;

  // Walk down from the top digit; digit 0 is never suppressed.
  always_comb begin
    w_sup  = '0;
    w_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero   = w_zero && (w_data_n[4*i +: 4] == 4'h0);
      w_sup[i] = w_lz_n && w_zero;
    end
  end

  assign w_nib = w_data_n[{w_d_n, 2'b00} +: 4];

  sseg_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  assign w_on  = (w_state_n == ST_ON);
  assign w_lit = (w_bright_n == 4'hF) ||
                 (w_p_n < w_bright_n);

  always_comb begin
    w_sel_n = '1;
    if (w_on) w_sel_n[w_d_n] = 1'b0;
  end

  assign w_hex_n =
    (w_on && w_lit && !w_sup[w_d_n]) ? w_seg : SEG_OFF;
  assign w_dpo_n = !(w_on && w_lit && w_dp_n[w_d_n]);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= ST_FIRST;
      r_cnt    <= '0;
      r_d      <= '0;
      r_p      <= '0;
      r_run    <= 1'b0;
      r_data   <= '0;
      r_dp     <= '0;
      r_lz     <= 1'b0;
      r_bright <= '0;
      r_sel    <= '1;
      r_hex    <= SEG_OFF;
      r_dpo    <= 1'b1;
      r_fs     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_d      <= w_d_n;
      r_p      <= w_p_n;
      r_run    <= 1'b1;
      r_data   <= w_data_n;
      r_dp     <= w_dp_n;
      r_lz     <= w_lz_n;
      r_bright <= w_bright_n;
      r_sel    <= w_sel_n;
      r_hex    <= w_hex_n;
      r_dpo    <= w_dpo_n;
      r_fs     <= w_snap;
    end
  end

  assign bus.SEL         = r_sel;
  assign bus.HEX         = r_hex;
  assign bus.DP          = r_dpo;
  assign bus.FRAME_START = r_fs;

endmodule
